// File: rtl/bru_q.sv
// Branch resolution unit with a result queue: resolves conditional branches and
// jalr, writes back link values, and queues outcomes in order for the pc generator.
module bru_q #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int RB    = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     flush,
    input  logic                     bru_exeparam_vaild,
    output logic                     bru_exeparam_ready,
    input  logic [7:0]               bru_op,
    input  logic                     is_rvc,
    input  logic                     bru_predict_taken,
    input  logic [XLEN-1:0]          bru_src1,
    input  logic [XLEN-1:0]          bru_src2,
    input  logic [XLEN-1:0]          bru_pc,
    input  logic [XLEN-1:0]          bru_imm,
    input  logic [5+RB-1:0]          bru_rd0,
    output logic                     res_vaild,
    input  logic                     res_ready,
    output logic                     res_taken,
    output logic                     res_redirect,
    output logic                     res_jalr,
    output logic [XLEN-1:0]          res_target,
    output logic                     bru_writeback_vaild,
    output logic [XLEN-1:0]          bru_res_qout,
    output logic [5+RB-1:0]          bru_rd0_qout,
    output logic [$clog2(DEPTH):0]   bru_q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    logic [XLEN-1:0] target_mem   [DEPTH];
    logic [DEPTH-1:0] taken_mem;
    logic [DEPTH-1:0] redirect_mem;
    logic [DEPTH-1:0] jalr_mem;

    // Decode is only trusted for a single set bit; anything else writes back 0 and never queues.
    logic op_onehot, is_jal, is_jalr, is_cond;
    assign op_onehot = (bru_op != 8'd0) && ((bru_op & (bru_op - 8'd1)) == 8'd0);
    assign is_jal    = op_onehot & bru_op[7];
    assign is_jalr   = op_onehot & bru_op[6];
    assign is_cond   = op_onehot & (|bru_op[5:0]);

    logic src_eq, src_lt, src_ltu, cond_taken;
    assign src_eq     = (bru_src1 == bru_src2);
    assign src_lt     = ($signed(bru_src1) < $signed(bru_src2));
    assign src_ltu    = (bru_src1 < bru_src2);
    assign cond_taken = (bru_op[5] &  src_eq)  | (bru_op[4] & ~src_eq) |
                        (bru_op[3] &  src_lt)  | (bru_op[2] & ~src_lt) |
                        (bru_op[1] &  src_ltu) | (bru_op[0] & ~src_ltu);

    logic [XLEN-1:0] link_pc, branch_target, jalr_sum, jalr_target;
    assign link_pc       = bru_pc + (is_rvc ? XLEN'(2) : XLEN'(4));
    assign branch_target = bru_pc + bru_imm;
    assign jalr_sum      = bru_src1 + bru_imm;
    assign jalr_target   = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};

    logic            new_taken, new_redirect;
    logic [XLEN-1:0] new_target;
    assign new_taken    = is_jalr | (is_cond & cond_taken);
    assign new_redirect = is_jalr | (cond_taken ^ bru_predict_taken);
    assign new_target   = is_jalr ? jalr_target : (cond_taken ? branch_target : link_pc);

    logic accept, enq, deq;
    assign bru_exeparam_ready = (count < CW'(DEPTH));
    assign accept             = bru_exeparam_vaild & bru_exeparam_ready & ~flush;
    assign enq                = accept & (is_cond | is_jalr);
    assign res_vaild          = (count != '0);
    assign deq                = res_vaild & res_ready & ~flush;

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (RST) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            if (enq && !deq)      count <= count + CW'(1);
            else if (deq && !enq) count <= count - CW'(1);
        end
    end

    // NOTE: the payload array has no reset; entries are only observed once count covers them.
    always_ff @(posedge CLK) begin
        if (!RST && enq) begin
            target_mem[wr_ptr]   <= new_target;
            taken_mem[wr_ptr]    <= new_taken;
            redirect_mem[wr_ptr] <= new_redirect;
            jalr_mem[wr_ptr]     <= is_jalr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bru_writeback_vaild <= 1'b0;
            bru_res_qout        <= '0;
            bru_rd0_qout        <= '0;
        end else begin
            bru_writeback_vaild <= accept;
            if (accept) begin
                bru_res_qout <= (is_jal | is_jalr) ? link_pc : '0;
                bru_rd0_qout <= bru_rd0;
            end
        end
    end

    assign res_taken    = taken_mem[rd_ptr];
    assign res_redirect = redirect_mem[rd_ptr];
    assign res_jalr     = jalr_mem[rd_ptr];
    assign res_target   = target_mem[rd_ptr];
    assign bru_q_count  = count;

endmodule

// File: doc/bru_q.md
BRU_Q -- requirements
Module: bru_q

Interface
REQ-001 Parameter XLEN, default 64: datapath width; legal values are 32 and 64.
REQ-002 Parameter DEPTH, default 4: result queue entries; must be a power of 2 and at least 2.
REQ-003 Parameter RB, default 2: rename bits on the destination tag.
REQ-004 Port CLK  in  1: clock; all state updates on the rising edge.
REQ-005 Port RST  in  1: reset, synchronous, active-high.
REQ-006 Port flush  in  1: pipeline flush.
REQ-007 Port bru_exeparam_vaild  in  1: issue valid.
REQ-008 Port bru_exeparam_ready  out  1: issue ready.
REQ-009 Port bru_op  in  8: one-hot operation, bit order {jal, jalr, eq, ne, lt, ge, ltu, geu}, jal is bit 7.
REQ-010 Port is_rvc  in  1: compressed instruction; link and fall-through offset is 2, otherwise 4.
REQ-011 Port bru_predict_taken  in  1: front-end prediction for conditional branches.
REQ-012 Port bru_src1 and bru_src2  in  XLEN each: operand values.
REQ-013 Port bru_pc and bru_imm  in  XLEN each: instruction pc and sign-extended immediate.
REQ-014 Port bru_rd0  in  5+RB: destination tag.
REQ-015 Port res_vaild  out  1: queue head valid toward the pc generator.
REQ-016 Port res_ready  in  1: pc generator accepts the head.
REQ-017 Port res_taken  out  1: head branch outcome.
REQ-018 Port res_redirect  out  1: head requires a fetch redirect.
REQ-019 Port res_jalr  out  1: head is a jalr.
REQ-020 Port res_target  out  XLEN: head resolved next pc.
REQ-021 Port bru_writeback_vaild  out  1: writeback valid.
REQ-022 Port bru_res_qout  out  XLEN: writeback data.
REQ-023 Port bru_rd0_qout  out  5+RB: writeback destination tag.
REQ-024 Port bru_q_count  out  clog2(DEPTH)+1: queue occupancy.

Function
REQ-025 bru_exeparam_ready SHALL equal (count < DEPTH); it depends only on registered count and has no same-cycle dequeue bypass.
REQ-026 Accept SHALL equal bru_exeparam_vaild & bru_exeparam_ready & ~flush.
REQ-027 On accept, bru_writeback_vaild SHALL be 1 in the next cycle.
REQ-028 On accept, bru_rd0_qout SHALL equal bru_rd0 in the next cycle.
REQ-029 On accept, bru_res_qout SHALL equal bru_pc+2 or bru_pc+4 (per is_rvc) for jal or jalr, and 0 otherwise.
REQ-030 Without accept, bru_writeback_vaild SHALL be 0 in the next cycle.
REQ-031 Enqueue SHALL occur on accept when bru_op is a conditional branch or jalr.
REQ-032 jal, and any non-one-hot or zero bru_op, SHALL write back but SHALL NOT enqueue.
REQ-033 Conditional branch taken conditions: eq is src1==src2; ne is src1!=src2; lt and ge use signed XLEN compare; ltu and geu use unsigned compare.
REQ-034 Conditional branch entry: taken per REQ-033; target = taken ? pc+imm : pc+2/4; redirect = taken XOR bru_predict_taken; jalr = 0.
REQ-035 jalr entry: taken = 1; target = (src1+imm) & ~1; redirect = 1; jalr = 1.
REQ-036 All target additions SHALL be modulo 2^XLEN with wrap-around and no overflow flag.
REQ-037 Queue order SHALL be FIFO, using read and write pointers of clog2(DEPTH) bits that wrap at DEPTH.
REQ-038 res_vaild SHALL equal (count != 0); the res_* outputs SHALL reflect the head entry directly from storage.
REQ-039 Enqueue-to-res_vaild latency SHALL be 1 cycle; a write into an empty queue is visible the next cycle.
REQ-040 Dequeue SHALL equal res_vaild & res_ready & ~flush.
REQ-041 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers; this is legal when the queue is full only if accept is true, which it is not (REQ-025).
REQ-042 res_ready while the queue is empty SHALL have no effect.
REQ-043 flush SHALL take priority: in that edge, count and both pointers reset to 0, with no enqueue, no dequeue, and next-cycle bru_writeback_vaild = 0.
REQ-044 Payload contents of unused or cleared entries are don't-care.

Reset
REQ-045 When RST=1 at an edge: count=0, pointers=0, res_vaild=0, bru_writeback_vaild=0, bru_res_qout=0, bru_rd0_qout=0.
REQ-046 Reset during operation SHALL discard all entries, behaving identically to flush, plus clearing the writeback registers.
REQ-047 Reset SHALL take priority over flush and accept.

Verification
REQ-048 beq with src1=src2=5, pc=0x1000, imm=0x40, predict_taken=0 -> next cycle res_vaild=1, taken=1, target=0x1040, redirect=1.
REQ-049 jalr with src1=0x2003, imm=0, is_rvc=1, pc=0x500, rd0=7 -> writeback res=0x502 with rd0=7, and the queue head has target=0x2002, redirect=1.
REQ-050 bltu with src1=0xFFFF_FFFF_FFFF_FFFF, src2=1 -> taken=0; blt with the same operands -> taken=1.
REQ-051 DEPTH=4, res_ready=0, push 4 branches -> bru_exeparam_ready=0 and count=4; then res_ready=1 for 1 cycle -> count=3, ready=1, heads appear in order.
REQ-052 Queue holding 3 entries plus flush together with valid issue -> next cycle count=0, res_vaild=0, bru_writeback_vaild=0.
REQ-053 10 back-to-back branches with res_ready=1 -> entries pass through the pointer wrap with order preserved and count never above 1.
